// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, fetch defaults and the
// fetch-buffer control state encoding.
package y86_pkg;

  localparam int FETCH_BYTES_DEFAULT = 10;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    LOAD = 2'd2
  } fetch_state_t;

  // Upper nibble of the first instruction byte is the icode.
  function automatic logic [3:0] icode_of(input logic [7:0] b);
    return b[7:4];
  endfunction

  // Lower nibble of the first instruction byte is the function code.
  function automatic logic [3:0] ifun_of(input logic [7:0] b);
    return b[3:0];
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// Byte-wide program storage: one synchronous write port and a combinational
// multi-byte read window starting at a base address.
module imem_byte_array #(
  parameter int DEPTH       = 2048,
  parameter int FETCH_BYTES = 10,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [7:0]               wdata,
  input  logic [AW-1:0]            raddr,
  output logic [8*FETCH_BYTES-1:0] rdata
);

  logic [7:0] mem [DEPTH];

  // Storage write; contents are intentionally never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Byte k of the window comes from base+k; the caller guarantees the window
  // does not wrap whenever the data is actually used.
  for (genvar k = 0; k < FETCH_BYTES; k++) begin : g_window
    assign rdata[8*k +: 8] = mem[raddr + AW'(k)];
  end

endmodule

// File: rtl/imem_fetch_buffer.sv
// Loadable Y86-64 instruction memory with a registered, stallable fetch port.
// A load always wins over a fetch; an out-of-range window returns zero bytes
// with imem_error set.
module imem_fetch_buffer
  import y86_pkg::*;
#(
  parameter int DEPTH       = 2048,
  parameter int FETCH_BYTES = FETCH_BYTES_DEFAULT,
  parameter int PC_W        = 64,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [AW-1:0]            load_addr,
  input  logic [7:0]               load_data,
  input  logic                     fetch_req,
  input  logic [PC_W-1:0]          pc,
  input  logic                     stall,
  output logic                     fetch_valid,
  output logic [8*FETCH_BYTES-1:0] fetch_bytes,
  output logic                     imem_error,
  output logic                     busy
);

  fetch_state_t              state_p1;
  logic [8*FETCH_BYTES-1:0]  window_p0;
  logic                      range_err_p0;
  logic                      mem_we_p0;

  // Last byte of the window is computed one bit wider than pc so an address
  // near the top of the pc space cannot wrap back into range.
  function automatic logic window_out_of_range(input logic [PC_W-1:0] addr);
    logic [PC_W:0] last;
    last = {1'b0, addr} + (PC_W+1)'(FETCH_BYTES - 1);
    return last > (PC_W+1)'(DEPTH - 1);
  endfunction

  // A write on the same edge that reset rises is discarded.
  assign mem_we_p0 = load_en & ~rst;
  assign busy      = load_en;

  imem_byte_array #(
    .DEPTH       (DEPTH),
    .FETCH_BYTES (FETCH_BYTES),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_p0),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc[AW-1:0]),
    .rdata (window_p0)
  );

  assign range_err_p0 = window_out_of_range(pc);

  // ---- stage p0 -> p1: accept load / hold / fetch and register the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1    <= IDLE;
      fetch_valid <= 1'b0;
      fetch_bytes <= '0;
      imem_error  <= 1'b0;
    end else if (load_en) begin
      state_p1    <= LOAD;
      fetch_valid <= 1'b0;
    end else if (state_p1 == RESP && stall) begin
      state_p1    <= RESP;
    end else if (fetch_req) begin
      state_p1    <= RESP;
      fetch_valid <= 1'b1;
      imem_error  <= range_err_p0;
      fetch_bytes <= range_err_p0 ? '0 : window_p0;
    end else begin
      state_p1    <= IDLE;
      fetch_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Randomised and directed bench for imem_fetch_buffer against a byte-array
// reference model.
module tb_imem_fetch_buffer;

  localparam int DEPTH = 2048;
  localparam int FB    = 10;
  localparam int PC_W  = 64;
  localparam int AW    = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_en;
  logic [AW-1:0]   load_addr;
  logic [7:0]      load_data;
  logic            fetch_req;
  logic [PC_W-1:0] pc;
  logic            stall;
  logic            fetch_valid;
  logic [8*FB-1:0] fetch_bytes;
  logic            imem_error;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]      m_mem [DEPTH];
  logic            m_valid;
  logic [8*FB-1:0] m_bytes;
  logic            m_err;

  always #5 clk = ~clk;

  imem_fetch_buffer #(
    .DEPTH       (DEPTH),
    .FETCH_BYTES (FB),
    .PC_W        (PC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .stall       (stall),
    .fetch_valid (fetch_valid),
    .fetch_bytes (fetch_bytes),
    .imem_error  (imem_error),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [8*FB-1:0] got, input logic [8*FB-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic pc_bad(input logic [63:0] a);
    return a > 64'(DEPTH - FB);
  endfunction

  function automatic logic [8*FB-1:0] exp_window(input logic [63:0] a);
    logic [8*FB-1:0] r;
    r = '0;
    if (!pc_bad(a))
      for (int k = 0; k < FB; k++) r[8*k +: 8] = m_mem[int'(a[31:0]) + k];
    return r;
  endfunction

  // One clock: check busy, apply the rules to the model at the edge, compare.
  task automatic cycle();
    #1;
    chk("busy", {79'b0, busy}, {79'b0, load_en});
    @(posedge clk);
    if (load_en) begin
      m_mem[load_addr] = load_data;
      m_valid = 1'b0;
    end else if (m_valid && stall) begin
      // response held
    end else if (fetch_req) begin
      m_valid = 1'b1;
      m_err   = pc_bad(pc);
      m_bytes = exp_window(pc);
    end else begin
      m_valid = 1'b0;
    end
    #1;
    chk("valid", {79'b0, fetch_valid}, {79'b0, m_valid});
    chk("bytes", fetch_bytes, m_bytes);
    chk("error", {79'b0, imem_error}, {79'b0, m_err});
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [7:0] d, input logic req);
    load_en = 1'b1; load_addr = a; load_data = d; fetch_req = req;
    pc = 64'(a); stall = 1'b0;
    cycle();
    load_en = 1'b0; fetch_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [63:0] a, input logic st);
    fetch_req = 1'b1; pc = a; stall = st;
    cycle();
    fetch_req = 1'b0; stall = 1'b0;
  endtask

  logic [7:0] prog [FB];
  logic [8*FB-1:0] held;

  initial begin
    prog = '{8'h30, 8'hFC, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    fetch_req = 1'b0; pc = '0; stall = 1'b0;
    m_valid = 1'b0; m_bytes = '0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {79'b0, fetch_valid}, '0);
    chk("rst_bytes", fetch_bytes, '0);
    chk("rst_error", {79'b0, imem_error}, '0);
    rst = 1'b0;

    // Fill the whole array; the program sits at address 1.
    for (int a = 0; a < DEPTH; a++) begin
      logic [7:0] d;
      d = (a >= 1 && a <= FB) ? prog[a-1] : 8'($urandom);
      do_load(AW'(a), d, 1'($urandom));
    end

    // Basic fetch of the program.
    do_fetch(64'd1, 1'b0);
    chk("p1_b0", {72'b0, fetch_bytes[7:0]}, 80'h30);
    chk("p1_b1", {72'b0, fetch_bytes[15:8]}, 80'hFC);
    chk("p1_b2", {72'b0, fetch_bytes[23:16]}, 80'h0A);
    chk("p1_err", {79'b0, imem_error}, '0);

    // Range boundaries.
    do_fetch(64'd2038, 1'b0);
    chk("pc2038_err", {79'b0, imem_error}, '0);
    do_fetch(64'd2039, 1'b0);
    chk("pc2039_err", {79'b0, imem_error}, 80'd1);
    chk("pc2039_bytes", fetch_bytes, '0);
    do_fetch(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("pcmax_err", {79'b0, imem_error}, 80'd1);
    chk("pcmax_valid", {79'b0, fetch_valid}, 80'd1);

    // Stall holds the response while pc moves.
    do_fetch(64'd1, 1'b0);
    held = fetch_bytes;
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; pc = 64'd11; stall = 1'b1;
      cycle();
      chk("stall_hold", fetch_bytes, held);
    end
    do_fetch(64'd11, 1'b0);
    chk("post_stall", fetch_bytes, exp_window(64'd11));

    // Back-to-back fetches.
    fetch_req = 1'b1; stall = 1'b0;
    pc = 64'd1;  cycle();
    pc = 64'd11; cycle();
    pc = 64'd21; cycle();
    chk("b2b_last", fetch_bytes, exp_window(64'd21));
    fetch_req = 1'b0;

    // Load beats a simultaneous fetch.
    load_en = 1'b1; load_addr = '0; load_data = 8'h10; fetch_req = 1'b1; pc = 64'd0;
    #1;
    chk("lp_busy", {79'b0, busy}, 80'd1);
    cycle();
    chk("lp_valid", {79'b0, fetch_valid}, '0);
    load_en = 1'b0; fetch_req = 1'b0;
    do_fetch(64'd0, 1'b0);
    chk("lp_b0", {72'b0, fetch_bytes[7:0]}, 80'h10);

    // Random traffic; loads stay clear of the program area.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      load_en   = ($urandom_range(0, 7) == 0);
      load_addr = AW'($urandom_range(32, DEPTH - 1));
      load_data = 8'($urandom);
      fetch_req = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      pc = 64'($urandom_range(2030, 2050));
      else if (sel == 1) pc = ~64'($urandom_range(0, 15));
      else if (sel == 2) pc = {$urandom, $urandom};
      else               pc = 64'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    load_en = 1'b0; fetch_req = 1'b0; stall = 1'b0;
    cycle();

    // Asynchronous reset in the middle of a response.
    do_fetch(64'd1, 1'b0);
    chk("pre_rst_valid", {79'b0, fetch_valid}, 80'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {79'b0, fetch_valid}, '0);
    chk("arst_bytes", fetch_bytes, '0);
    chk("arst_error", {79'b0, imem_error}, '0);
    m_valid = 1'b0; m_bytes = '0; m_err = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    do_fetch(64'd1, 1'b0);
    chk("retain_b0", {72'b0, fetch_bytes[7:0]}, 80'h30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
